// File: rtl/dram_req_scheduler_if.sv
// Request, issue and response signals shared by the
// two requesters, the DRAM port and the scheduler.
interface dram_req_scheduler_if #(
  parameter int CNT_W = 5
);
  logic             stall;
  logic             req0_valid;
  logic [31:0]      req0_addr_k;
  logic [31:0]      req0_addr_l;
  logic             req0_ready;
  logic             req1_valid;
  logic [31:0]      req1_addr_k;
  logic [31:0]      req1_addr_l;
  logic             req1_ready;
  logic             DRAM_valid;
  logic [31:0]      addr_k;
  logic [31:0]      addr_l;
  logic             DRAM_get;
  logic             resp0_valid;
  logic             resp1_valid;
  logic [CNT_W-1:0] outstanding;
  logic             idle;
  logic             resp_err;

  modport master (
    output stall,
    output req0_valid, req0_addr_k, req0_addr_l,
    input  req0_ready,
    output req1_valid, req1_addr_k, req1_addr_l,
    input  req1_ready,
    input  DRAM_valid, addr_k, addr_l,
    output DRAM_get,
    input  resp0_valid, resp1_valid,
    input  outstanding, idle, resp_err
  );

  modport slave (
    input  stall,
    input  req0_valid, req0_addr_k, req0_addr_l,
    output req0_ready,
    input  req1_valid, req1_addr_k, req1_addr_l,
    output req1_ready,
    output DRAM_valid, addr_k, addr_l,
    input  DRAM_get,
    output resp0_valid, resp1_valid,
    output outstanding, idle, resp_err
  );
endinterface

// File: rtl/dram_req_scheduler.sv
// Round-robin, credit-limited sharing of one DRAM port
// between two requesters, with in-order response steering.
module dram_req_scheduler #(
  parameter int MAX_OUT = 16,
  parameter int CNT_W   = 5
) (
  input logic Clk_32UI,
  input logic reset_n,
  dram_req_scheduler_if.slave bus
);
  localparam int PW = $clog2(MAX_OUT);

  logic             dv_q, dv_d;
  logic [31:0]      k_q, k_d;
  logic [31:0]      l_q, l_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [MAX_OUT-1:0] fifo_q, fifo_d;

  logic both, gsel, can_issue;
  logic rdy0, rdy1, acc, pop, head;

  always_comb begin
    both      = bus.req0_valid & bus.req1_valid;
    gsel      = both ? ~last_q : bus.req1_valid;
    can_issue = ~bus.stall
              & (out_q < CNT_W'(MAX_OUT));
    rdy0      = can_issue & bus.req0_valid & ~gsel;
    rdy1      = can_issue & bus.req1_valid & gsel;
    acc       = rdy0 | rdy1;
    pop       = bus.DRAM_get & (out_q != '0);
    head      = fifo_q[rd_q];
  end

  always_comb begin
    dv_d   = acc;
    k_d    = k_q;
    l_d    = l_q;
    last_d = last_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fifo_d = fifo_q;
    err_d  = err_q | (bus.DRAM_get & (out_q == '0));
    out_d  = out_q + CNT_W'(acc) - CNT_W'(pop);
    if (acc) begin
      k_d          = gsel ? bus.req1_addr_k : bus.req0_addr_k;
      l_d          = gsel ? bus.req1_addr_l : bus.req0_addr_l;
      last_d       = gsel;
      fifo_d[wr_q] = gsel;
      wr_d         = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // last_q resets to 1 so requester 0 wins the first tie
  always_ff @(posedge Clk_32UI) begin
    if (!reset_n) begin
      dv_q   <= 1'b0;
      k_q    <= '0;
      l_q    <= '0;
      out_q  <= '0;
      last_q <= 1'b1;
      err_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      fifo_q <= '0;
    end else begin
      dv_q   <= dv_d;
      k_q    <= k_d;
      l_q    <= l_d;
      out_q  <= out_d;
      last_q <= last_d;
      err_q  <= err_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fifo_q <= fifo_d;
    end
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.DRAM_valid  = dv_q;
  assign bus.addr_k      = k_q;
  assign bus.addr_l      = l_q;
  assign bus.resp0_valid = pop & ~head;
  assign bus.resp1_valid = pop & head;
  assign bus.outstanding = out_q;
  assign bus.idle        = (out_q == '0) & ~dv_q;
  assign bus.resp_err    = err_q;
endmodule
